// File: rtl/reg_2bytes_uart_rx_pkg.sv
// Shared definitions for the UART byte-pair framing blocks:
// FSM state encoding, byte width and the default inter-byte timeout.
package uart_pkg;

  localparam int BYTE_W                 = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1_000_000;

  localparam logic [1:0] RX2_IDLE     = 2'b00;
  localparam logic [1:0] RX2_WAIT_TWO = 2'b01;
  localparam logic [1:0] RX2_PUBLISH  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE     = RX2_IDLE,
    S_WAIT_TWO = RX2_WAIT_TWO,
    S_PUBLISH  = RX2_PUBLISH
  } rx2_state_t;

  // lo holds the first byte received, hi the second
  typedef struct packed {
    logic [BYTE_W-1:0] hi;
    logic [BYTE_W-1:0] lo;
  } byte_pair_t;

endpackage

// File: rtl/reg_2bytes_uart_rx_if.sv
// Byte stream in from the UART receiver, byte pair out to the command decoder.
interface reg_2bytes_uart_rx_if;
  import uart_pkg::*;

  logic [BYTE_W-1:0] data_rx;
  logic              done_rx;
  logic [BYTE_W-1:0] byte_one;
  logic [BYTE_W-1:0] byte_two;
  logic              done;
  logic              timeout_err;

  modport master (
    output data_rx,
    output done_rx,
    input  byte_one,
    input  byte_two,
    input  done,
    input  timeout_err
  );

  modport slave (
    input  data_rx,
    input  done_rx,
    output byte_one,
    output byte_two,
    output done,
    output timeout_err
  );

endinterface

// File: rtl/reg_2bytes_uart_rx_gap_timer.sv
// Saturating gap counter: counts while run is high and flags the terminal
// cycle (TIMEOUT_CYCLES-1). TIMEOUT_CYCLES=0 disables it and holds the count at 0.
module uart_gap_timer #(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int CNT_W          = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam bit               ENABLED  = (TIMEOUT_CYCLES != 0);
  localparam int               TERM_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] TERM     = CNT_W'(TERM_INT);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_term;

  assign w_at_term = (r_cnt == TERM);

  // Stops at the terminal value instead of wrapping, so a stalled sender
  // cannot make the timer alias back to a short gap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear || !ENABLED) begin
      r_cnt <= '0;
    end else if (run && !w_at_term) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired = ENABLED && run && w_at_term;

endmodule

// File: rtl/reg_2bytes_uart_rx.sv
// Assembles two consecutive UART bytes into a pair with a one-cycle done pulse;
// a half-received pair is dropped with timeout_err if byte two is too late.
module reg_2bytes_uart_rx
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  reg_2bytes_uart_rx_if.slave   bus
);

  rx2_state_t        r_state;
  rx2_state_t        w_state_next;
  byte_pair_t        r_buf;
  byte_pair_t        w_buf_next;
  logic [BYTE_W-1:0] r_byte_one;
  logic [BYTE_W-1:0] w_byte_one_next;
  logic [BYTE_W-1:0] r_byte_two;
  logic [BYTE_W-1:0] w_byte_two_next;
  logic              r_done;
  logic              w_done_next;
  logic              r_timeout_err;
  logic              w_timeout_err_next;

  logic              w_timer_clear;
  logic              w_timer_run;
  logic              w_timer_expired;

  // A byte arriving outside WAIT_TWO always starts a new pair.
  assign w_timer_clear = bus.done_rx && (r_state != S_WAIT_TWO);
  assign w_timer_run   = (r_state == S_WAIT_TWO) && !bus.done_rx;

  uart_gap_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_gap_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_timer_clear),
    .run     (w_timer_run),
    .expired (w_timer_expired)
  );

  always_comb begin
    w_state_next       = r_state;
    w_buf_next         = r_buf;
    w_byte_one_next    = r_byte_one;
    w_byte_two_next    = r_byte_two;
    w_done_next        = 1'b0;
    w_timeout_err_next = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.done_rx) begin
          w_buf_next.lo = bus.data_rx;
          w_state_next  = S_WAIT_TWO;
        end
      end

      // done_rx has priority over the timer on the terminal cycle
      S_WAIT_TWO: begin
        if (bus.done_rx) begin
          w_buf_next.hi = bus.data_rx;
          w_state_next  = S_PUBLISH;
        end else if (w_timer_expired) begin
          w_timeout_err_next = 1'b1;
          w_buf_next         = '0;
          w_state_next       = S_IDLE;
        end
      end

      S_PUBLISH: begin
        w_byte_one_next = r_buf.lo;
        w_byte_two_next = r_buf.hi;
        w_done_next     = 1'b1;
        if (bus.done_rx) begin
          w_buf_next.lo = bus.data_rx;
          w_state_next  = S_WAIT_TWO;
        end else begin
          w_state_next  = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_buf         <= '0;
      r_byte_one    <= '0;
      r_byte_two    <= '0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_buf         <= w_buf_next;
      r_byte_one    <= w_byte_one_next;
      r_byte_two    <= w_byte_two_next;
      r_done        <= w_done_next;
      r_timeout_err <= w_timeout_err_next;
    end
  end

  assign bus.byte_one    = r_byte_one;
  assign bus.byte_two    = r_byte_two;
  assign bus.done        = r_done;
  assign bus.timeout_err = r_timeout_err;

endmodule
